// File: rtl/clut_video_out.sv
// Raster timing and CLUT output stage: generates pixel/line counters for the fetch path,
// realigns returned CLUT colour with delayed sync/blank, and holds the palette bank steady per frame.
module clut_video_out #(
    parameter int H_TOTAL      = 384,
    parameter int H_ACTIVE     = 288,
    parameter int H_SYNC_START = 304,
    parameter int H_SYNC_WIDTH = 32,
    parameter int V_TOTAL      = 264,
    parameter int V_ACTIVE     = 224,
    parameter int V_SYNC_START = 240,
    parameter int V_SYNC_WIDTH = 8,
    parameter int LATENCY      = 2
) (
    input  logic       CLK_6M,
    input  logic       CLR,
    input  logic [7:0] R_IN,
    input  logic [7:0] G_IN,
    input  logic [7:0] B_IN,
    input  logic       BANK_REQ,
    output logic       BANK,
    output logic [8:0] HCNT,
    output logic [8:0] VCNT,
    output logic       HBLANK,
    output logic       VBLANK,
    output logic       VBLANK_IRQ,
    output logic [7:0] R,
    output logic [7:0] G,
    output logic [7:0] B,
    output logic       HSYNC_N,
    output logic       VSYNC_N,
    output logic       BLANK_N
);

    localparam logic [8:0] H_LAST   = 9'(H_TOTAL - 1);
    localparam logic [8:0] V_LAST   = 9'(V_TOTAL - 1);
    localparam logic [8:0] H_ACT    = 9'(H_ACTIVE);
    localparam logic [8:0] V_ACT    = 9'(V_ACTIVE);
    localparam logic [9:0] HS_BEGIN = 10'(H_SYNC_START);
    localparam logic [9:0] HS_END   = 10'(H_SYNC_START + H_SYNC_WIDTH);
    localparam logic [9:0] VS_BEGIN = 10'(V_SYNC_START);
    localparam logic [9:0] VS_END   = 10'(V_SYNC_START + V_SYNC_WIDTH);

    logic [8:0] h_next;
    logic [8:0] v_next;
    logic       vblank_start;
    logic       hs;
    logic       vs;
    logic       vis;
    logic       hs_d;
    logic       vs_d;
    logic       vis_d;

    always_comb begin
        h_next = HCNT + 9'd1;
        v_next = VCNT;
        if (HCNT == H_LAST) begin
            h_next = 9'd0;
            v_next = (VCNT == V_LAST) ? 9'd0 : VCNT + 9'd1;
        end
    end

    // Decoded from the next counter state so the IRQ and bank load land on the
    // same edge that moves the counters to (0, V_ACTIVE).
    assign vblank_start = (h_next == 9'd0) && (v_next == V_ACT);

    always_ff @(posedge CLK_6M or negedge CLR) begin
        if (!CLR) begin
            HCNT       <= 9'd0;
            VCNT       <= 9'd0;
            VBLANK_IRQ <= 1'b0;
            BANK       <= 1'b0;
        end else begin
            HCNT       <= h_next;
            VCNT       <= v_next;
            VBLANK_IRQ <= vblank_start;
            if (vblank_start) begin
                BANK <= BANK_REQ;
            end
        end
    end

    assign HBLANK = HCNT >= H_ACT;
    assign VBLANK = VCNT >= V_ACT;
    assign hs     = ({1'b0, HCNT} >= HS_BEGIN) && ({1'b0, HCNT} < HS_END);
    assign vs     = ({1'b0, VCNT} >= VS_BEGIN) && ({1'b0, VCNT} < VS_END);
    assign vis    = !HBLANK && !VBLANK;

    // Delay line matching the CLUT fetch latency; stage LATENCY-1 lines up with *_IN.
    generate
        if (LATENCY == 1) begin : g_pipe_one
            logic [2:0] pipe;
            always_ff @(posedge CLK_6M or negedge CLR) begin
                if (!CLR) begin
                    pipe <= 3'b000;
                end else begin
                    pipe <= {hs, vs, vis};
                end
            end
            assign hs_d  = pipe[2];
            assign vs_d  = pipe[1];
            assign vis_d = pipe[0];
        end else begin : g_pipe_multi
            logic [LATENCY-1:0] hs_pipe;
            logic [LATENCY-1:0] vs_pipe;
            logic [LATENCY-1:0] vis_pipe;
            always_ff @(posedge CLK_6M or negedge CLR) begin
                if (!CLR) begin
                    hs_pipe  <= '0;
                    vs_pipe  <= '0;
                    vis_pipe <= '0;
                end else begin
                    hs_pipe  <= {hs_pipe[LATENCY-2:0], hs};
                    vs_pipe  <= {vs_pipe[LATENCY-2:0], vs};
                    vis_pipe <= {vis_pipe[LATENCY-2:0], vis};
                end
            end
            assign hs_d  = hs_pipe[LATENCY-1];
            assign vs_d  = vs_pipe[LATENCY-1];
            assign vis_d = vis_pipe[LATENCY-1];
        end
    endgenerate

    always_ff @(posedge CLK_6M or negedge CLR) begin
        if (!CLR) begin
            R       <= 8'd0;
            G       <= 8'd0;
            B       <= 8'd0;
            HSYNC_N <= 1'b1;
            VSYNC_N <= 1'b1;
            BLANK_N <= 1'b0;
        end else begin
            R       <= vis_d ? R_IN : 8'd0;
            G       <= vis_d ? G_IN : 8'd0;
            B       <= vis_d ? B_IN : 8'd0;
            HSYNC_N <= !hs_d;
            VSYNC_N <= !vs_d;
            BLANK_N <= vis_d;
        end
    end

endmodule

// File: tb/tb_clut_video_out.sv
// Bench for clut_video_out on a shrunken raster: a counter model predicts every
// output, with expected RGB/sync words queued LATENCY+1 clocks ahead.
module tb_clut_video_out;

    localparam int H_TOTAL      = 24;
    localparam int H_ACTIVE     = 16;
    localparam int H_SYNC_START = 18;
    localparam int H_SYNC_WIDTH = 3;
    localparam int V_TOTAL      = 12;
    localparam int V_ACTIVE     = 8;
    localparam int V_SYNC_START = 9;
    localparam int V_SYNC_WIDTH = 2;
    localparam int LATENCY      = 2;
    localparam int FRAME        = H_TOTAL * V_TOTAL;

    logic       CLK_6M = 1'b0;
    logic       CLR;
    logic [7:0] R_IN, G_IN, B_IN;
    logic       BANK_REQ;
    logic       BANK;
    logic [8:0] HCNT, VCNT;
    logic       HBLANK, VBLANK, VBLANK_IRQ;
    logic [7:0] R, G, B;
    logic       HSYNC_N, VSYNC_N, BLANK_N;

    clut_video_out #(
        .H_TOTAL(H_TOTAL), .H_ACTIVE(H_ACTIVE),
        .H_SYNC_START(H_SYNC_START), .H_SYNC_WIDTH(H_SYNC_WIDTH),
        .V_TOTAL(V_TOTAL), .V_ACTIVE(V_ACTIVE),
        .V_SYNC_START(V_SYNC_START), .V_SYNC_WIDTH(V_SYNC_WIDTH),
        .LATENCY(LATENCY)
    ) dut (
        .CLK_6M(CLK_6M), .CLR(CLR),
        .R_IN(R_IN), .G_IN(G_IN), .B_IN(B_IN),
        .BANK_REQ(BANK_REQ), .BANK(BANK),
        .HCNT(HCNT), .VCNT(VCNT),
        .HBLANK(HBLANK), .VBLANK(VBLANK), .VBLANK_IRQ(VBLANK_IRQ),
        .R(R), .G(G), .B(B),
        .HSYNC_N(HSYNC_N), .VSYNC_N(VSYNC_N), .BLANK_N(BLANK_N)
    );

    always #5 CLK_6M = ~CLK_6M;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       hsn;
        logic       vsn;
        logic       bn;
    } out_t;

    out_t        exp_q[$];
    logic [23:0] data_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int m_h, m_v, cyc;
    logic m_bank, m_irq;
    int irq_cnt = 0;
    int last_irq = -1;
    int hs_low = 0;
    int vs_low = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h (h=%0d v=%0d)", tag, got, exp, m_h, m_v);
        end
    endtask

    task automatic reset_model();
        out_t rst;
        m_h = 0; m_v = 0; cyc = 0;
        m_bank = 1'b0; m_irq = 1'b0;
        last_irq = -1;
        rst = '{r: 8'd0, g: 8'd0, b: 8'd0, hsn: 1'b1, vsn: 1'b1, bn: 1'b0};
        exp_q.delete();
        data_q.delete();
        for (int i = 0; i < LATENCY + 1; i++) exp_q.push_back(rst);
    endtask

    // Check the current clock, queue this pixel's expectation, drive inputs, advance.
    task automatic step();
        out_t e, p;
        logic vis, hs, vs;
        logic [7:0] col;
        logic [23:0] d;
        int nh, nv;

        chk("hcnt", 32'(HCNT), 32'(m_h));
        chk("vcnt", 32'(VCNT), 32'(m_v));
        chk("hblank", 32'(HBLANK), 32'(m_h >= H_ACTIVE));
        chk("vblank", 32'(VBLANK), 32'(m_v >= V_ACTIVE));
        chk("irq", 32'(VBLANK_IRQ), 32'(m_irq));
        chk("bank", 32'(BANK), 32'(m_bank));
        e = exp_q.pop_front();
        chk("r", 32'(R), 32'(e.r));
        chk("g", 32'(G), 32'(e.g));
        chk("b", 32'(B), 32'(e.b));
        chk("hsync_n", 32'(HSYNC_N), 32'(e.hsn));
        chk("vsync_n", 32'(VSYNC_N), 32'(e.vsn));
        chk("blank_n", 32'(BLANK_N), 32'(e.bn));

        if (HSYNC_N === 1'b0) hs_low++;
        if (VSYNC_N === 1'b0) vs_low++;
        if (VBLANK_IRQ === 1'b1) begin
            irq_cnt++;
            if (last_irq >= 0) chk("irq_spacing", 32'(cyc - last_irq), 32'(FRAME));
            last_irq = cyc;
        end

        vis = (m_h < H_ACTIVE) && (m_v < V_ACTIVE);
        hs  = (m_h >= H_SYNC_START) && (m_h < H_SYNC_START + H_SYNC_WIDTH);
        vs  = (m_v >= V_SYNC_START) && (m_v < V_SYNC_START + V_SYNC_WIDTH);
        col = 8'(m_h);
        d   = {col, col ^ 8'h5A, 8'(m_v)};
        p.r = vis ? d[23:16] : 8'd0;
        p.g = vis ? d[15:8]  : 8'd0;
        p.b = vis ? d[7:0]   : 8'd0;
        p.hsn = !hs;
        p.vsn = !vs;
        p.bn  = vis;
        exp_q.push_back(p);

        data_q.push_back(d);
        if (data_q.size() == LATENCY + 1) begin
            d = data_q.pop_front();
            R_IN = d[23:16]; G_IN = d[15:8]; B_IN = d[7:0];
        end else begin
            R_IN = 8'hC3; G_IN = 8'h3C; B_IN = 8'h99;
        end

        nh = m_h + 1;
        nv = m_v;
        if (m_h == H_TOTAL - 1) begin
            nh = 0;
            nv = (m_v == V_TOTAL - 1) ? 0 : m_v + 1;
        end
        m_irq = (nh == 0) && (nv == V_ACTIVE);
        if (m_irq) m_bank = BANK_REQ;
        m_h = nh;
        m_v = nv;
        cyc++;
        @(posedge CLK_6M);
        #1;
    endtask

    task automatic run_to(input int h, input int v);
        for (int i = 0; i < FRAME + 1 && !(m_h == h && m_v == v); i++) step();
    endtask

    initial begin
        CLR = 1'b0;
        BANK_REQ = 1'b1;
        R_IN = 8'hFF; G_IN = 8'hFF; B_IN = 8'hFF;
        m_h = 0; m_v = 0;

        // Reset held for 5 clocks with live-looking inputs.
        repeat (5) @(posedge CLK_6M);
        #1;
        chk("rst_hcnt", 32'(HCNT), 32'd0);
        chk("rst_vcnt", 32'(VCNT), 32'd0);
        chk("rst_r", 32'(R), 32'd0);
        chk("rst_g", 32'(G), 32'd0);
        chk("rst_b", 32'(B), 32'd0);
        chk("rst_hsync_n", 32'(HSYNC_N), 32'd1);
        chk("rst_vsync_n", 32'(VSYNC_N), 32'd1);
        chk("rst_blank_n", 32'(BLANK_N), 32'd0);
        chk("rst_bank", 32'(BANK), 32'd0);
        chk("rst_irq", 32'(VBLANK_IRQ), 32'd0);

        BANK_REQ = 1'b0;
        @(negedge CLK_6M);
        CLR = 1'b1;
        reset_model();

        // Start-up: BLANK_N first rises LATENCY+1 clocks after release.
        step();
        chk("hcnt_edge1", 32'(HCNT), 32'd1);
        step();
        chk("blank_n_edge2", 32'(BLANK_N), 32'd0);
        step();
        chk("blank_n_edge3", 32'(BLANK_N), 32'd1);

        // Three bank toggles in one frame resolve to the level at vblank start.
        run_to(5, 2);  BANK_REQ = 1'b1;
        run_to(10, 4); BANK_REQ = 1'b0;
        run_to(3, 6);  BANK_REQ = 1'b1;
        run_to(H_TOTAL - 1, V_ACTIVE - 1);
        chk("bank_before_vblank", 32'(BANK), 32'd0);
        step();
        chk("bank_at_irq", 32'(BANK), 32'd1);
        chk("irq_at_vblank", 32'(VBLANK_IRQ), 32'd1);

        // Toggle away and back within a frame: bank stays put.
        run_to(4, 1);  BANK_REQ = 1'b0;
        run_to(6, 3);  BANK_REQ = 1'b1;
        run_to(0, V_ACTIVE);
        chk("bank_kept", 32'(BANK), 32'd1);

        run_to(2, 5);  BANK_REQ = 1'b0;
        run_to(0, V_ACTIVE);
        chk("bank_cleared", 32'(BANK), 32'd0);

        // One full frame of sync counts.
        run_to(0, 0);
        hs_low = 0;
        vs_low = 0;
        repeat (FRAME) step();
        chk("hsync_low_per_frame", 32'(hs_low), 32'(V_TOTAL * H_SYNC_WIDTH));
        chk("vsync_low_per_frame", 32'(vs_low), 32'(H_TOTAL * V_SYNC_WIDTH));
        chk("irq_count", 32'(irq_cnt), 32'd4);

        // Mid-frame reset inside vertical sync.
        BANK_REQ = 1'b1;
        run_to(10, 9);
        chk("vsync_before_reset", 32'(VSYNC_N), 32'd0);
        CLR = 1'b0;
        #1;
        chk("mid_rst_vsync_n", 32'(VSYNC_N), 32'd1);
        chk("mid_rst_r", 32'(R), 32'd0);
        chk("mid_rst_blank_n", 32'(BLANK_N), 32'd0);
        chk("mid_rst_hcnt", 32'(HCNT), 32'd0);
        chk("mid_rst_vcnt", 32'(VCNT), 32'd0);
        chk("mid_rst_bank", 32'(BANK), 32'd0);
        repeat (3) @(posedge CLK_6M);
        @(negedge CLK_6M);
        CLR = 1'b1;
        reset_model();

        for (int i = 0; i < FRAME && VSYNC_N !== 1'b0; i++) step();
        chk("first_vsync_low", 32'(VSYNC_N), 32'd0);
        chk("first_vsync_vcnt", 32'(VCNT), 32'(V_SYNC_START));
        repeat (2 * H_TOTAL) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
